// File: rtl/shift_normalizer_pkg.sv
// Shared definitions for the shift normalizer.
//   NORM_W       default operand width
//   NORM_STAGES  binary-search steps (and RUN cycles) for NORM_W
//   norm_state_e control FSM encoding
package shift_normalizer_pkg;

    localparam int unsigned NORM_W      = 32;
    localparam int unsigned NORM_STAGES = $clog2(NORM_W);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } norm_state_e;

endpackage

// File: rtl/shift_normalizer_norm_step.sv
// One binary-search step of the left normalizer (combinational).
// Evaluates a shift of 2^k_i on work_i and reports whether it is taken.
//   work_i       current work word
//   k_i          stage index; step size is 2^k_i
//   is_signed_i  0: step taken if top s bits are zero
//                1: step taken if top s+1 bits are all equal
//   work_o       work_i << 2^k_i (zero-fill)
//   amt_o        step size 2^k_i
//   taken_o      step condition holds
module shift_normalizer_norm_step #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0]  work_i,
    input  logic [STAGES-1:0] k_i,
    input  logic              is_signed_i,
    output logic [WIDTH-1:0]  work_o,
    output logic [STAGES-1:0] amt_o,
    output logic              taken_o
);

    logic [WIDTH-1:0] probe;
    logic [WIDTH-1:0] top_mask;

    always_comb begin
        amt_o    = STAGES'(1) << k_i;
        // Bit i of the signed probe is set when bits i and i-1 differ, so "top s+1 bits
        // equal" becomes "top s probe bits zero", same test as the unsigned case.
        probe    = is_signed_i ? (work_i ^ (work_i << 1)) : work_i;
        top_mask = ~({WIDTH{1'b1}} >> amt_o);
        taken_o  = ((probe & top_mask) == '0);
        work_o   = work_i << amt_o;
    end

endmodule

// File: rtl/shift_normalizer.sv
// Multi-cycle left normalizer: shifts an operand left until its MSB is significant,
// one binary-search stage per cycle (WIDTH/2, ..., 2, 1), behind valid/ready handshakes.
//   clk, rst_n   clock, synchronous active-low reset
//   in_valid     request valid;  in_ready high only in IDLE
//   in_data      operand;        in_signed selects MSB=1 (0) or bit[W-1]!=bit[W-2] (1)
//   out_valid    result valid, held until out_ready
//   out_data     normalized operand; out_count shift applied; out_zero operand was zero
module shift_normalizer
    import shift_normalizer_pkg::*;
#(
    parameter  int unsigned WIDTH  = NORM_W,
    localparam int unsigned STAGES = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_signed,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [STAGES-1:0] out_count,
    output logic              out_zero
);

    norm_state_e       state_q, state_d;
    logic [WIDTH-1:0]  work_q, work_d;
    logic [STAGES-1:0] count_q, count_d;
    logic [STAGES-1:0] k_q, k_d;
    logic              zero_q, zero_d;
    logic              sgn_q, sgn_d;

    logic [WIDTH-1:0]  step_work;
    logic [STAGES-1:0] step_amt;
    logic              step_taken;

    shift_normalizer_norm_step #(
        .WIDTH  (WIDTH),
        .STAGES (STAGES)
    ) u_norm_step (
        .work_i      (work_q),
        .k_i         (k_q),
        .is_signed_i (sgn_q),
        .work_o      (step_work),
        .amt_o       (step_amt),
        .taken_o     (step_taken)
    );

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        count_d   = count_q;
        k_d       = k_q;
        zero_d    = zero_q;
        sgn_d     = sgn_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        out_count = '0;
        out_zero  = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    work_d  = in_data;
                    count_d = '0;
                    k_d     = STAGES'(STAGES - 1);
                    zero_d  = (in_data == '0);
                    sgn_d   = in_signed;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (step_taken) begin
                    work_d  = step_work;
                    // Sum of distinct powers below WIDTH, so it never exceeds WIDTH-1.
                    count_d = count_q + step_amt;
                end
                if (k_q == '0) begin
                    state_d = StDone;
                end else begin
                    k_d = k_q - 1'b1;
                end
            end
            StDone: begin
                // Outputs are gated to DONE so intermediate work is never visible.
                out_valid = 1'b1;
                out_data  = work_q;
                out_count = count_q;
                out_zero  = zero_q;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            work_q  <= '0;
            count_q <= '0;
            k_q     <= '0;
            zero_q  <= 1'b0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            count_q <= count_d;
            k_q     <= k_d;
            zero_q  <= zero_d;
            sgn_q   <= sgn_d;
        end
    end

endmodule

// File: tb/tb_shift_normalizer.sv
// Self-checking bench for shift_normalizer: scoreboard of expected results pushed at accept,
// popped at the output handshake; directed boundaries, DONE stall, mid-RUN reset, random ops.
module tb_shift_normalizer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        in_signed = 1'b0;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_count;
    logic        out_zero;

    logic stall_rand = 1'b0;
    logic rand_ready = 1'b1;
    logic force_ready = 1'b1;
    assign out_ready = stall_rand ? rand_ready : force_ready;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    logic prev_valid = 1'b0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  count;
        logic        zero;
        int          acc;
    } exp_t;
    exp_t sb[$];

    shift_normalizer #(
        .WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: linear scan for leading zeros / redundant sign bits.
    function automatic exp_t model(input logic [31:0] d, input logic s, input int acc);
        exp_t e;
        int   c = 0;
        if (!s) begin
            while (c < 31 && d[31-c] == 1'b0) c++;
        end else begin
            while (c < 31 && d[30-c] == d[31]) c++;
        end
        e.data  = d << c;
        e.count = 5'(c);
        e.zero  = (d == 32'h0);
        e.acc   = acc;
        return e;
    endfunction

    // Output monitor: latency on first valid cycle, scoreboard compare on handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!prev_valid && sb.size() != 0) check_eq("latency", 32'(cyc - sb[0].acc), 32'd5);
            if (out_ready) begin
                if (sb.size() == 0) begin
                    check_eq("unexpected_out", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("out_data", out_data, e.data);
                    check_eq("out_count", 32'(out_count), 32'(e.count));
                    check_eq("out_zero", 32'(out_zero), 32'(e.zero));
                end
            end
        end
        prev_valid <= rst_n && out_valid;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rand_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [31:0] d, input logic s);
        int n = 0;
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_data   = d;
        in_signed = s;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check_eq("accept_timeout", 32'd0, 32'd1);
        else sb.push_back(model(d, s, cyc + 1));
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_data   = $urandom;
        in_signed = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) check_eq("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] hold_data;
        logic [4:0]  hold_count;
        logic        hold_zero;
        int          n;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", out_data, 32'd0);
        check_eq("rst_out_count", 32'(out_count), 32'd0);
        check_eq("rst_out_zero", 32'(out_zero), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Directed values and boundaries
        send(32'h0000_0001, 1'b0);
        send(32'h0000_0001, 1'b1);
        send(32'hFFFF_FFFE, 1'b1);
        send(32'h0000_0000, 1'b0);
        send(32'h8000_0000, 1'b0);
        send(32'h0000_0000, 1'b1);
        send(32'hFFFF_FFFF, 1'b1);
        send(32'h4000_0000, 1'b1);
        send(32'h0001_2345, 1'b0);
        wait_drain();

        // Stall in DONE: outputs stable, in_valid ignored
        force_ready = 1'b0;
        send(32'h0000_1234, 1'b0);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("stall_reach_done", 32'(out_valid), 32'd1);
        hold_data  = out_data;
        hold_count = out_count;
        hold_zero  = out_zero;
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_data   = 32'h0000_BEEF;
        in_signed = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check_eq("stall_valid", 32'(out_valid), 32'd1);
            check_eq("stall_in_ready", 32'(in_ready), 32'd0);
            check_eq("stall_data", out_data, hold_data);
            check_eq("stall_count", 32'(out_count), 32'(hold_count));
            check_eq("stall_zero", 32'(out_zero), 32'(hold_zero));
            @(posedge clk);
            #1;
        end
        force_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("post_hs_in_ready", 32'(in_ready), 32'd1);
        check_eq("post_hs_out_valid", 32'(out_valid), 32'd0);
        sb.push_back(model(32'h0000_BEEF, 1'b0, cyc + 1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_drain();

        // Reset during the second RUN cycle
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_data   = 32'h00F0_0000;
        in_signed = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_out_valid", 32'(out_valid), 32'd0);
        check_eq("abort_in_ready", 32'(in_ready), 32'd1);
        check_eq("abort_out_count", 32'(out_count), 32'd0);
        check_eq("abort_out_data", out_data, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(32'h0000_0F00, 1'b1);
        wait_drain();

        // Random ops, both modes, random output stalls
        stall_rand = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            logic [31:0] d;
            logic        s;
            int          sh;
            s  = 1'($urandom_range(0, 1));
            sh = $urandom_range(0, 32);
            d  = $urandom;
            d  = (sh == 32) ? 32'h0 : (d >> sh);
            if (s && $urandom_range(0, 1) == 1) d = ~d;
            send(d, s);
        end
        wait_drain();
        stall_rand = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
